// File: rtl/chr_gen_pkg.sv
// Shared types for the character-generator VRAM write path.
// No logic here: widths and the state/grant encodings only.
package chr_gen_pkg;

  localparam int C_VRAM_AW_DEF = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fill_st_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_A    = 2'd1,
    GNT_F    = 2'd2
  } gnt_e;

endpackage

// File: rtl/chr_vram_fill_seq.sv
// Fill sequencer: latches a fill command and walks cells one per adv pulse.
// Latency: pend the cycle after an accepted req; stalls (idx held) while adv=0.
module chr_vram_fill_seq
  import chr_gen_pkg::*;
#(
  parameter int AW = C_VRAM_AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  input  logic [7:0]    chr,
  input  logic          inc,
  input  logic          adv,
  output logic          pend,
  output logic          last,
  output logic          nxt_fill,
  output logic          zero_req,
  output logic [AW-1:0] addr,
  output logic [7:0]    data
);

  fill_st_e      state;
  logic [AW-1:0] base_q;
  logic [AW:0]   len_q;
  logic [7:0]    chr_q;
  logic          inc_q;
  logic [AW-1:0] idx;
  logic [7:0]    idx8;
  logic          start;

  assign start    = (state == ST_IDLE) && req && (len != '0);
  assign zero_req = (state == ST_IDLE) && req && (len == '0);
  assign pend     = (state == ST_FILL);
  // len_q is one bit wider than idx so a full 2^AW run still terminates.
  assign last     = ({1'b0, idx} == (len_q - (AW+1)'(1)));
  assign nxt_fill = start || (pend && !(adv && last));

  assign idx8 = 8'(idx);
  assign addr = base_q + idx;
  assign data = chr_q + (inc_q ? idx8 : 8'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      base_q <= '0;
      len_q  <= '0;
      chr_q  <= '0;
      inc_q  <= 1'b0;
      idx    <= '0;
    end else if (start) begin
      state  <= ST_FILL;
      base_q <= base;
      len_q  <= len;
      chr_q  <= chr;
      inc_q  <= inc;
      idx    <= '0;
    end else if (pend && adv) begin
      idx <= idx + AW'(1);
      if (last) begin
        state <= ST_IDLE;
      end
    end
  end

endmodule

// File: rtl/chr_vram_wr_arb.sv
// Round-robin arbiter of host (A) and fill (F) writes onto the CHR VRAM port.
// Latency: grant to WE one cycle; requesters wait (A holds REQ) while the window is closed.
module chr_vram_wr_arb
  import chr_gen_pkg::*;
#(
  parameter int C_VRAM_AW = C_VRAM_AW_DEF,
  parameter bit C_WIN_EN  = 1'b1
) (
  input  logic                 CK_i,
  input  logic                 XSYS_R_i,
  input  logic                 WIN_i,
  input  logic                 A_REQ_i,
  input  logic [C_VRAM_AW-1:0] A_WAs_i,
  input  logic [7:0]           A_WDs_i,
  output logic                 A_ACK_o,
  input  logic                 FILL_REQ_i,
  input  logic [C_VRAM_AW-1:0] FILL_BASE_i,
  input  logic [C_VRAM_AW:0]   FILL_LEN_i,
  input  logic [7:0]           FILL_CHR_i,
  input  logic                 FILL_INC_i,
  output logic                 FILL_BUSY_o,
  output logic                 FILL_DONE_o,
  output logic [C_VRAM_AW-1:0] CPU_VRAM_WAs_o,
  output logic [7:0]           CPU_VRAM_WDs_o,
  output logic                 CPU_VRAM_WE_o,
  output logic                 OSD_CPU_USE_o
);

  logic                 win_open;
  logic                 prio_f;
  gnt_e                 gnt;
  logic                 f_pend;
  logic                 f_last;
  logic                 f_nxt_fill;
  logic                 f_zero;
  logic [C_VRAM_AW-1:0] f_addr;
  logic [7:0]           f_data;

  chr_vram_fill_seq #(
    .AW(C_VRAM_AW)
  ) u_fill_seq (
    .clk      (CK_i),
    .rst_n    (XSYS_R_i),
    .req      (FILL_REQ_i),
    .base     (FILL_BASE_i),
    .len      (FILL_LEN_i),
    .chr      (FILL_CHR_i),
    .inc      (FILL_INC_i),
    .adv      (gnt == GNT_F),
    .pend     (f_pend),
    .last     (f_last),
    .nxt_fill (f_nxt_fill),
    .zero_req (f_zero),
    .addr     (f_addr),
    .data     (f_data)
  );

  assign win_open = WIN_i || !C_WIN_EN;

  // prio_f names the side that wins the next tie.
  always_comb begin
    gnt = GNT_NONE;
    if (win_open) begin
      if (A_REQ_i && f_pend) begin
        gnt = prio_f ? GNT_F : GNT_A;
      end else if (A_REQ_i) begin
        gnt = GNT_A;
      end else if (f_pend) begin
        gnt = GNT_F;
      end
    end
  end

  assign A_ACK_o     = (gnt == GNT_A);
  assign FILL_BUSY_o = f_pend;

  always_ff @(posedge CK_i or negedge XSYS_R_i) begin
    if (!XSYS_R_i) begin
      prio_f         <= 1'b1;
      CPU_VRAM_WE_o  <= 1'b0;
      CPU_VRAM_WAs_o <= '0;
      CPU_VRAM_WDs_o <= '0;
      FILL_DONE_o    <= 1'b0;
      OSD_CPU_USE_o  <= 1'b0;
    end else begin
      CPU_VRAM_WE_o <= (gnt != GNT_NONE);
      FILL_DONE_o   <= ((gnt == GNT_F) && f_last) || f_zero;
      OSD_CPU_USE_o <= f_nxt_fill || (gnt != GNT_NONE);
      if (gnt == GNT_A) begin
        prio_f         <= 1'b1;
        CPU_VRAM_WAs_o <= A_WAs_i;
        CPU_VRAM_WDs_o <= A_WDs_i;
      end else if (gnt == GNT_F) begin
        prio_f         <= 1'b0;
        CPU_VRAM_WAs_o <= f_addr;
        CPU_VRAM_WDs_o <= f_data;
      end
    end
  end

endmodule

// File: tb/tb_chr_vram_wr_arb.sv
// Scoreboard bench for chr_vram_wr_arb: stimulus pushes expected writes,
// a negedge monitor pops and compares whenever WE or DONE is presented.
module tb_chr_vram_wr_arb;

  typedef struct {
    logic       we;
    logic [9:0] addr;
    logic [7:0] data;
    logic       done;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       win = 1'b1;
  logic       a_req = 1'b0;
  logic [9:0] a_was = '0;
  logic [7:0] a_wds = '0;
  logic       a_ack;
  logic       fill_req = 1'b0;
  logic [9:0] fill_base = '0;
  logic [10:0] fill_len = '0;
  logic [7:0] fill_chr = '0;
  logic       fill_inc = 1'b0;
  logic       fill_busy;
  logic       fill_done;
  logic [9:0] vram_was;
  logic [7:0] vram_wds;
  logic       vram_we;
  logic       cpu_use;

  exp_t sb[$];
  int   checks = 0;
  int   fails = 0;
  int   we_cnt = 0;
  int   busy_cnt = 0;

  chr_vram_wr_arb dut (
    .CK_i           (clk),
    .XSYS_R_i       (rst_n),
    .WIN_i          (win),
    .A_REQ_i        (a_req),
    .A_WAs_i        (a_was),
    .A_WDs_i        (a_wds),
    .A_ACK_o        (a_ack),
    .FILL_REQ_i     (fill_req),
    .FILL_BASE_i    (fill_base),
    .FILL_LEN_i     (fill_len),
    .FILL_CHR_i     (fill_chr),
    .FILL_INC_i     (fill_inc),
    .FILL_BUSY_o    (fill_busy),
    .FILL_DONE_o    (fill_done),
    .CPU_VRAM_WAs_o (vram_was),
    .CPU_VRAM_WDs_o (vram_wds),
    .CPU_VRAM_WE_o  (vram_we),
    .OSD_CPU_USE_o  (cpu_use)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    fails++;
    $display("FAIL %s timed out t=%0t", name, $time);
  endtask

  task automatic push(input logic we, input logic [9:0] addr, input logic [7:0] data, input logic done);
    exp_t e;
    e.we = we;
    e.addr = addr;
    e.data = data;
    e.done = done;
    sb.push_back(e);
  endtask

  task automatic push_fill(input logic [9:0] base, input int len, input logic [7:0] chr, input logic inc);
    for (int i = 0; i < len; i++) begin
      push(1'b1, base + 10'(i), inc ? chr + 8'(i) : chr, i == len - 1);
    end
  endtask

  // Monitor: every WE or DONE must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fill_busy) busy_cnt++;
      if (vram_we) begin
        we_cnt++;
        chk("cpu_use_during_we", 32'(cpu_use), 32'd1);
      end
      if (vram_we || fill_done) begin
        if (sb.size() == 0) begin
          fails++;
          checks++;
          $display("FAIL unexpected_write we=%0b addr=%0h data=%0h done=%0b required=none",
                   vram_we, vram_was, vram_wds, fill_done);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("we", 32'(vram_we), 32'(e.we));
          if (e.we) begin
            chk("addr", 32'(vram_was), 32'(e.addr));
            chk("data", 32'(vram_wds), 32'(e.data));
          end
          chk("done", 32'(fill_done), 32'(e.done));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_cmd(input logic [9:0] base, input logic [10:0] len, input logic [7:0] chr, input logic inc);
    fill_base = base;
    fill_len = len;
    fill_chr = chr;
    fill_inc = inc;
    fill_req = 1'b1;
    tick();
    fill_req = 1'b0;
  endtask

  // Leaves REQ high after the grant edge; caller drops it.
  task automatic a_write(input logic [9:0] addr, input logic [7:0] data);
    bit got;
    got = 1'b0;
    a_was = addr;
    a_wds = data;
    a_req = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (a_ack) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) timeout_fail("a_ack_wait");
    tick();
  endtask

  task automatic drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail(name);
    repeat (3) tick();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_we"}, 32'(vram_we), 32'd0);
    chk({tag, "_was"}, 32'(vram_was), 32'd0);
    chk({tag, "_wds"}, 32'(vram_wds), 32'd0);
    chk({tag, "_done"}, 32'(fill_done), 32'd0);
    chk({tag, "_busy"}, 32'(fill_busy), 32'd0);
    chk({tag, "_cpu_use"}, 32'(cpu_use), 32'd0);
    chk({tag, "_ack"}, 32'(a_ack), 32'd0);
  endtask

  initial begin
    int s;
    int cnt;
    bit hit;

    #12;
    chk_outputs_zero("reset");
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // Single host write
    push(1'b1, 10'h015, 8'h41, 1'b0);
    a_was = 10'h015;
    a_wds = 8'h41;
    a_req = 1'b1;
    @(negedge clk);
    chk("single_ack", 32'(a_ack), 32'd1);
    tick();
    a_req = 1'b0;
    drain("single_drain");

    // Contention: last grant was A, so F wins the first tie
    push(1'b1, 10'h100, 8'h80, 1'b0);
    push(1'b1, 10'h200, 8'hA0, 1'b0);
    push(1'b1, 10'h101, 8'h81, 1'b0);
    push(1'b1, 10'h201, 8'hA1, 1'b0);
    push(1'b1, 10'h102, 8'h82, 1'b0);
    push(1'b1, 10'h202, 8'hA2, 1'b0);
    push(1'b1, 10'h103, 8'h83, 1'b0);
    push(1'b1, 10'h104, 8'h84, 1'b0);
    push(1'b1, 10'h105, 8'h85, 1'b1);
    s = we_cnt;
    fill_cmd(10'h100, 11'd6, 8'h80, 1'b1);
    a_write(10'h200, 8'hA0);
    a_write(10'h201, 8'hA1);
    a_write(10'h202, 8'hA2);
    a_req = 1'b0;
    drain("contention_drain");
    chk("contention_we_total", 32'(we_cnt - s), 32'd9);

    // Wrap fill
    push(1'b1, 10'h3FE, 8'h30, 1'b0);
    push(1'b1, 10'h3FF, 8'h31, 1'b0);
    push(1'b1, 10'h000, 8'h32, 1'b0);
    push(1'b1, 10'h001, 8'h33, 1'b1);
    busy_cnt = 0;
    fill_cmd(10'h3FE, 11'd4, 8'h30, 1'b1);
    drain("wrap_drain");
    chk("wrap_busy_cycles", 32'(busy_cnt), 32'd4);

    // Window gating: two cells go out, then the window shuts for 10 cycles
    push_fill(10'h050, 5, 8'h61, 1'b0);
    fill_cmd(10'h050, 11'd5, 8'h61, 1'b0);
    tick();
    tick();
    win = 1'b0;
    a_was = 10'h3A0;
    a_wds = 8'hEE;
    a_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("closed_ack", 32'(a_ack), 32'd0);
      if (i > 0) chk("closed_we", 32'(vram_we), 32'd0);
      tick();
    end
    a_req = 1'b0;
    win = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (vram_we) cnt++;
    end
    chk("reopen_we_no_gap", 32'(cnt), 32'd3);
    drain("gating_drain");

    // Zero length
    push(1'b0, 10'h000, 8'h00, 1'b1);
    fill_cmd(10'h123, 11'd0, 8'h77, 1'b1);
    @(negedge clk);
    chk("zero_done", 32'(fill_done), 32'd1);
    chk("zero_busy", 32'(fill_busy), 32'd0);
    drain("zero_drain");

    // Request while busy is dropped
    push_fill(10'h020, 3, 8'h10, 1'b0);
    fill_cmd(10'h020, 11'd3, 8'h10, 1'b0);
    fill_base = 10'h300;
    fill_len = 11'd2;
    fill_chr = 8'h99;
    fill_req = 1'b1;
    tick();
    fill_req = 1'b0;
    drain("busy_drain");
    repeat (5) tick();
    chk("busy_idle_after", 32'(fill_busy), 32'd0);

    // Reset mid-fill after three writes
    push_fill(10'h180, 8, 8'h40, 1'b1);
    s = we_cnt;
    fill_cmd(10'h180, 11'd8, 8'h40, 1'b1);
    hit = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      #1;
      if (we_cnt >= s + 3) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) timeout_fail("reset_wait_writes");
    chk("pre_reset_we", 32'(vram_we), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk_outputs_zero("async_reset");
    sb.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    chk_outputs_zero("post_reset");
    push(1'b1, 10'h000, 8'h55, 1'b0);
    push(1'b1, 10'h001, 8'h55, 1'b1);
    fill_cmd(10'h000, 11'd2, 8'h55, 1'b0);
    drain("post_reset_drain");

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "global timeout");
  end

endmodule
